// File: rtl/quad_window_counter_pkg.sv
// Shared constants for the hba_quad decoder, window counter and peripheral top.
// Also holds the control-mode encoding used by the window counter.
package quad_window_counter_pkg;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // 1 ms tick at the 50 MHz hba_clk
    localparam int TICK_DIV_DEFAULT = 50000;

    localparam int ENC_LEFT  = 0;
    localparam int ENC_RIGHT = 1;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_CLEAR = 2'd1,
        MODE_RUN   = 2'd2
    } mode_t;

endpackage

// File: rtl/quad_tick_gen.sv
// Prescaler: emits a registered one-cycle tick every TICK_DIV clocks while run=1.
// Dropping run restarts the count, so a fresh run always waits a full period.
module quad_tick_gen
    import quad_window_counter_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/quad_window_counter.sv
// Signed saturating edge accumulator over a programmable tick window; publishes
// a registered snapshot with a one-cycle valid strobe at each window end.
module quad_window_counter
    import quad_window_counter_pkg::*;
#(
    parameter int COUNT_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 8,
    parameter int TICK_DIV     = TICK_DIV_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clear,
    input  logic                          pulse_in,
    input  logic                          dir_in,
    input  logic [PERIOD_WIDTH-1:0]       period,
    output logic signed [COUNT_WIDTH-1:0] count,
    output logic                          valid,
    output logic                          overflow
);

    localparam logic signed [COUNT_WIDTH:0] MAX_VAL = {2'b00, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic signed [COUNT_WIDTH:0] MIN_VAL = {2'b11, {(COUNT_WIDTH-1){1'b0}}};

    function automatic logic signed [COUNT_WIDTH-1:0] sat_value(input logic signed [COUNT_WIDTH:0] x);
        if (x > MAX_VAL)
            return MAX_VAL[COUNT_WIDTH-1:0];
        else if (x < MIN_VAL)
            return MIN_VAL[COUNT_WIDTH-1:0];
        else
            return x[COUNT_WIDTH-1:0];
    endfunction

    function automatic logic sat_hit(input logic signed [COUNT_WIDTH:0] x);
        return (x > MAX_VAL) || (x < MIN_VAL);
    endfunction

    mode_t                          mode;
    logic                           run;
    logic                           tick;
    logic signed [COUNT_WIDTH-1:0]  acc;
    logic                           sat;
    logic [PERIOD_WIDTH-1:0]        win_cnt;
    logic [PERIOD_WIDTH:0]          win_inc;
    logic                           wend;
    logic signed [COUNT_WIDTH:0]    delta;
    logic signed [COUNT_WIDTH:0]    sum;
    logic signed [COUNT_WIDTH-1:0]  next_acc;
    logic                           step_sat;

    always_comb begin
        mode = MODE_RUN;
        if (clear)
            mode = MODE_CLEAR;
        else if (!en || (period == '0))
            mode = MODE_IDLE;
    end

    assign run = (mode == MODE_RUN);

    quad_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        delta = '0;
        if (pulse_in)
            delta = (dir_in == DIR_FWD) ? {{COUNT_WIDTH{1'b0}}, 1'b1} : '1;
    end

    // One bit of headroom so a step past either limit is visible before clamping
    assign sum      = $signed({acc[COUNT_WIDTH-1], acc}) + delta;
    assign next_acc = sat_value(sum);
    assign step_sat = sat_hit(sum);

    // >= rather than == so a shrinking period closes the window at the next tick
    assign win_inc = {1'b0, win_cnt} + {{PERIOD_WIDTH{1'b0}}, 1'b1};
    assign wend    = run && tick && (win_inc >= {1'b0, period});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            sat      <= 1'b0;
            win_cnt  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            case (mode)
                MODE_CLEAR: begin
                    acc      <= '0;
                    sat      <= 1'b0;
                    win_cnt  <= '0;
                    count    <= '0;
                    overflow <= 1'b0;
                    valid    <= 1'b0;
                end
                MODE_RUN: begin
                    valid <= wend;
                    if (wend) begin
                        count    <= next_acc;
                        overflow <= sat | step_sat;
                        acc      <= '0;
                        sat      <= 1'b0;
                        win_cnt  <= '0;
                    end else begin
                        acc <= next_acc;
                        sat <= sat | step_sat;
                        if (tick)
                            win_cnt <= win_inc[PERIOD_WIDTH-1:0];
                    end
                end
                default: begin
                    acc     <= '0;
                    sat     <= 1'b0;
                    win_cnt <= '0;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_window_counter.sv
// Bench for quad_window_counter: 16-bit and 4-bit instances share stimulus and are
// compared each cycle against a window-level model, plus directed literal checks.
module tb_quad_window_counter;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset, en, clear, pulse_in, dir_in;
    logic [7:0] period;

    logic signed [15:0] count16;
    logic               valid16, ovf16;
    logic signed [3:0]  count4;
    logic               valid4, ovf4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    quad_window_counter #(.COUNT_WIDTH(16), .PERIOD_WIDTH(8), .TICK_DIV(TD)) u_dut16 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .pulse_in(pulse_in),
        .dir_in(dir_in), .period(period), .count(count16), .valid(valid16), .overflow(ovf16)
    );

    quad_window_counter #(.COUNT_WIDTH(4), .PERIOD_WIDTH(8), .TICK_DIV(TD)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .pulse_in(pulse_in),
        .dir_in(dir_in), .period(period), .count(count4), .valid(valid4), .overflow(ovf4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Window-level model: ticks fall every TD running cycles after the first full
    // prescale period; a window closes on the tick where ticks-so-far+1 >= period.
    int  lim_max[2] = '{32767, 7};
    int  lim_min[2] = '{-32768, -8};
    int  m_acc[2], m_sat[2], e_cnt[2], e_ovf[2];
    int  e_valid;
    int  runlen, ticks, d, s, hit;
    bit  tick_now, wend_now;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < 2; w++) begin
                m_acc[w] = 0; m_sat[w] = 0; e_cnt[w] = 0; e_ovf[w] = 0;
            end
            e_valid = 0; runlen = 0; ticks = 0;
        end else if (clear) begin
            for (int w = 0; w < 2; w++) begin
                m_acc[w] = 0; m_sat[w] = 0; e_cnt[w] = 0; e_ovf[w] = 0;
            end
            e_valid = 0; runlen = 0; ticks = 0;
        end else if (!en || period == 0) begin
            for (int w = 0; w < 2; w++) begin
                m_acc[w] = 0; m_sat[w] = 0;
            end
            e_valid = 0; runlen = 0; ticks = 0;
        end else begin
            runlen++;
            tick_now = (runlen > TD) && ((runlen - 1) % TD == 0);
            wend_now = tick_now && (ticks + 1 >= int'(period));
            d = pulse_in ? (dir_in ? 1 : -1) : 0;
            for (int w = 0; w < 2; w++) begin
                s = m_acc[w] + d;
                hit = (s > lim_max[w] || s < lim_min[w]) ? 1 : 0;
                if (s > lim_max[w]) s = lim_max[w];
                if (s < lim_min[w]) s = lim_min[w];
                if (wend_now) begin
                    e_cnt[w] = s; e_ovf[w] = m_sat[w] | hit; m_acc[w] = 0; m_sat[w] = 0;
                end else begin
                    m_acc[w] = s; m_sat[w] = m_sat[w] | hit;
                end
            end
            e_valid = wend_now ? 1 : 0;
            if (wend_now) ticks = 0;
            else if (tick_now) ticks++;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("cyc_valid16", valid16, e_valid);
            check("cyc_valid4", valid4, e_valid);
            check("cyc_count16", count16, e_cnt[0]);
            check("cyc_count4", count4, e_cnt[1]);
            check("cyc_ovf16", ovf16, e_ovf[0]);
            check("cyc_ovf4", ovf4, e_ovf[1]);
        end
    end

    task automatic adv();
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_window(input int per);
        en = 1'b0;
        adv();
        period = 8'(per);
        en = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_valid();
        int guard = 0;
        do begin
            adv();
            guard++;
        end while (!valid16 && guard < 300);
        check("wait_valid", valid16, 1);
    endtask

    task automatic pulses(input int n, input logic dir);
        pulse_in = 1'b1;
        dir_in = dir;
        repeat (n) adv();
        pulse_in = 1'b0;
    endtask

    int nv;
    int n_rand_valid;
    int bias;

    initial begin
        reset = 1'b0; en = 1'b0; clear = 1'b0; pulse_in = 1'b0; dir_in = 1'b1; period = 8'd3;
        adv();
        check("rst_count16", count16, 0);
        check("rst_valid16", valid16, 0);
        check("rst_ovf16", ovf16, 0);
        adv();
        reset = 1'b1;
        adv();

        // 5 forward pulses, period 3: snapshot 13 cycles after enable
        start_window(3);
        pulses(5, 1'b1);
        wait_valid();
        check("p1_latency", cyc, 13);
        check("p1_count16", count16, 5);
        check("p1_ovf16", ovf16, 0);
        check("p1_model", e_cnt[0], 5);
        adv();
        check("p1_valid_one_cycle", valid16, 0);

        // 7 forward + 10 reverse, then an empty window
        start_window(6);
        pulses(7, 1'b1);
        pulses(10, 1'b0);
        wait_valid();
        check("p2_count16", count16, -3);
        check("p2_hex16", longint'($unsigned(count16)), 64'hFFFD);
        check("p2_count4", count4, -3);
        wait_valid();
        check("p2_empty_count16", count16, 0);

        // Saturation in the 4-bit instance
        start_window(3);
        pulses(9, 1'b1);
        wait_valid();
        check("p3_count16", count16, 9);
        check("p3_count4", count4, 7);
        check("p3_ovf4", ovf4, 1);
        check("p3_ovf16", ovf16, 0);
        pulses(2, 1'b0);
        wait_valid();
        check("p3b_count4", count4, -2);
        check("p3b_ovf4", ovf4, 0);

        // Pulse on the wend cycle closes into this window; wend+1 goes to the next
        start_window(3);
        repeat (12) adv();
        pulse_in = 1'b1; dir_in = 1'b1;
        adv();
        check("p4_valid_at_wend", valid16, 1);
        check("p4_count16", count16, 1);
        dir_in = 1'b0;
        adv();
        pulse_in = 1'b0;
        wait_valid();
        check("p4_next_count16", count16, -1);
        check("p4_next_cyc", cyc, 25);

        // Clear coincident with wend and a pulse
        start_window(3);
        repeat (12) adv();
        clear = 1'b1; pulse_in = 1'b1; dir_in = 1'b1;
        adv();
        check("p5_valid", valid16, 0);
        check("p5_count16", count16, 0);
        check("p5_ovf16", ovf16, 0);
        clear = 1'b0; pulse_in = 1'b0;
        cyc = 0;
        wait_valid();
        check("p5_next_cyc", cyc, 13);
        check("p5_next_count16", count16, 0);

        // Period shrink mid-window, then period 0, then async reset mid-window
        start_window(10);
        pulses(9, 1'b1);
        while (cyc < 22) adv();
        period = 8'd2;
        wait_valid();
        check("p6_shrink_cyc", cyc, 25);
        check("p6_count16", count16, 9);
        check("p6_count4", count4, 7);
        check("p6_ovf4", ovf4, 1);
        period = 8'd0;
        nv = 0;
        repeat (40) begin
            adv();
            if (valid16) nv++;
        end
        check("p6_no_valid", nv, 0);
        check("p6_hold_count16", count16, 9);
        period = 8'd3;
        pulses(6, 1'b1);
        #3 reset = 1'b0;
        #1;
        check("p6_rst_count16", count16, 0);
        check("p6_rst_count4", count4, 0);
        check("p6_rst_ovf4", ovf4, 0);
        check("p6_rst_valid16", valid16, 0);
        adv();
        adv();
        reset = 1'b1;

        // Randomized traffic
        n_rand_valid = 0;
        bias = 60;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) bias = $urandom_range(20, 80);
            if ($urandom_range(0, 149) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            clear = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 399) == 0) period = 8'($urandom_range(0, 4));
            pulse_in = ($urandom_range(0, 1) == 1);
            dir_in = ($urandom_range(0, 99) < bias);
            adv();
            if (valid16) n_rand_valid++;
        end
        check("rand_saw_valids", (n_rand_valid > 10) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
